// File: rtl/child_status_collector.sv
// -----------------------------------------------------------------------------
// child_status_collector
//
// Merges framed status streams from N_CHILD children into one upstream
// stream. Every beat is tagged with the index of the child it came from.
// Frames are never interleaved.
//
// Between frames the children are served round-robin. Once a child has won
// the first beat of a multi-beat frame, that child owns the output until it
// sends its last beat. A single registered output stage can be drained and
// reloaded on the same edge, so the block sustains one beat per cycle.
//
// Parameters
//   N_CHILD : number of child channels (2..16)
//   DATA_W  : payload width per beat
//   ID_W    : child tag width, 2**ID_W >= N_CHILD
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : per-child beat valid
//   in_data     : per-child payload, child i at [i*DATA_W +: DATA_W]
//   in_last     : per-child last beat of frame
//   in_ready    : per-child accept (combinational, at most one bit high)
//   out_valid   : upstream beat valid (registered)
//   out_data    : upstream payload (registered)
//   out_id      : source child index (registered)
//   out_last    : upstream last beat of frame (registered)
//   out_ready   : upstream accept
//
// Optional feature (macro COLLECTOR_STATS_EN)
//   frame_cnt   : saturating count of accepted last beats
//   err_gap     : sticky flag, set when the owning child stalls mid-frame
//                 while the output stage could have taken a beat
// -----------------------------------------------------------------------------
module child_status_collector #(
    parameter int N_CHILD = 5,
    parameter int DATA_W  = 16,
    parameter int ID_W    = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CHILD-1:0]          in_valid,
    input  logic [N_CHILD*DATA_W-1:0]   in_data,
    input  logic [N_CHILD-1:0]          in_last,
    output logic [N_CHILD-1:0]          in_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [ID_W-1:0]             out_id,
    output logic                        out_last,
    input  logic                        out_ready
`ifdef COLLECTOR_STATS_EN
    ,
    output logic [15:0]                 frame_cnt,
    output logic                        err_gap
`endif
);

    // Padded copies let an ID_W-wide index address the vectors directly.
    localparam int NP = 2 ** ID_W;

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [ID_W-1:0]      rr_ptr_r;
    logic [ID_W-1:0]      lock_r;

    logic [NP-1:0]        valid_pad_s;
    logic [NP-1:0]        last_pad_s;
    logic                 arb_any_s;
    logic [ID_W-1:0]      arb_idx_s;
    logic                 sel_any_s;
    logic [ID_W-1:0]      sel_idx_s;
    logic [N_CHILD-1:0]   sel_s;
    logic                 load_s;
    logic                 accept_s;
    logic                 grant_last_s;
    logic [DATA_W-1:0]    grant_data_s;
    logic [ID_W-1:0]      rr_next_s;

    assign valid_pad_s = NP'(in_valid);
    assign last_pad_s  = NP'(in_last);

    // Round-robin search: first valid child at or after rr_ptr, wrapping mod N_CHILD.
    always_comb begin
        logic [ID_W:0] cand_v;
        logic          hit_v;
        arb_any_s = 1'b0;
        arb_idx_s = '0;
        cand_v    = '0;
        hit_v     = 1'b0;
        for (int k = 0; k < N_CHILD; k++) begin
            cand_v = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
            cand_v = (cand_v >= (ID_W+1)'(N_CHILD)) ? (cand_v - (ID_W+1)'(N_CHILD)) : cand_v;
            hit_v     = !arb_any_s && valid_pad_s[cand_v[ID_W-1:0]];
            arb_idx_s = hit_v ? cand_v[ID_W-1:0] : arb_idx_s;
            arb_any_s = arb_any_s | hit_v;
        end
    end

    // FSM output logic: pick the serviced child and drive the handshake.
    always_comb begin
        sel_any_s = 1'b0;
        sel_idx_s = '0;
        case (state_r)
            ST_ARB: begin
                sel_any_s = arb_any_s;
                sel_idx_s = arb_idx_s;
            end
            ST_LOCK: begin
                // Only the owner may advance; a stalled owner just waits.
                sel_any_s = valid_pad_s[lock_r];
                sel_idx_s = lock_r;
            end
            default: begin
                sel_any_s = 1'b0;
                sel_idx_s = '0;
            end
        endcase

        load_s   = !out_valid || out_ready;
        accept_s = load_s && sel_any_s;

        grant_data_s = '0;
        for (int i = 0; i < N_CHILD; i++) begin
            sel_s[i]     = sel_any_s && (sel_idx_s == ID_W'(i));
            grant_data_s = grant_data_s |
                           ((sel_idx_s == ID_W'(i)) ? in_data[i*DATA_W +: DATA_W] : '0);
        end
        grant_last_s = last_pad_s[sel_idx_s];

        // Hold every child off while reset is asserted.
        in_ready = (rst_n && load_s) ? sel_s : '0;

        rr_next_s = (sel_idx_s == ID_W'(N_CHILD - 1)) ? '0 : (sel_idx_s + ID_W'(1));
    end

    // FSM next-state logic: lock on a non-final first beat, release on the last beat.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ARB:  state_nxt_s = (accept_s && !grant_last_s) ? ST_LOCK : ST_ARB;
            ST_LOCK: state_nxt_s = (accept_s &&  grant_last_s) ? ST_ARB  : ST_LOCK;
            default: state_nxt_s = ST_ARB;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_ARB;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Owner and round-robin pointer; the pointer moves only at end of frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
            lock_r   <= '0;
        end else begin
            if (accept_s && grant_last_s) begin
                rr_ptr_r <= rr_next_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            if ((state_r == ST_ARB) && accept_s && !grant_last_s) begin
                lock_r <= sel_idx_s;
            end else begin
                lock_r <= lock_r;
            end
        end
    end

    // Output stage: reload on accept, otherwise empty when drained, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
        end else if (accept_s) begin
            out_valid <= 1'b1;
            out_data  <= grant_data_s;
            out_id    <= sel_idx_s;
            out_last  <= grant_last_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

`ifdef COLLECTOR_STATS_EN
    // Frame counter (saturating) and sticky mid-frame gap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'h0000;
            err_gap   <= 1'b0;
        end else begin
            if (accept_s && grant_last_s && (frame_cnt != 16'hFFFF)) begin
                frame_cnt <= frame_cnt + 16'h0001;
            end else begin
                frame_cnt <= frame_cnt;
            end
            if ((state_r == ST_LOCK) && load_s && !valid_pad_s[lock_r]) begin
                err_gap <= 1'b1;
            end else begin
                err_gap <= err_gap;
            end
        end
    end
`endif

endmodule

// File: tb/tb_child_status_collector.sv
// -----------------------------------------------------------------------------
// Bench for child_status_collector: directed scenarios followed by random
// traffic, all compared every cycle against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_child_status_collector;

    localparam int N  = 5;
    localparam int DW = 16;
    localparam int IW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      in_valid;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_last;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_id;
    logic              out_last;
    logic              out_ready;
`ifdef COLLECTOR_STATS_EN
    logic [15:0]       frame_cnt;
    logic              err_gap;
`endif

    always #5 clk = ~clk;

    child_status_collector #(.N_CHILD(N), .DATA_W(DW), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .out_ready (out_ready)
`ifdef COLLECTOR_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .err_gap   (err_gap)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: who owns the output, where the next search starts,
    // and what the single output slot must contain.
    int          owner;
    int          rr;
    bit          exp_valid;
    logic [15:0] exp_data;
    int          exp_id;
    bit          exp_last;
    int          m_frames;
    bit          m_gap;
    int          last_acc;

    // DUT values observed in the latest step, plus the log of delivered beats.
    bit          obs_valid;
    logic [15:0] obs_data;
    logic [N-1:0] obs_ready;
    int          seen_id[$];
    int          seen_last[$];

    // Random child generators.
    bit          ch_has  [N];
    int          ch_left [N];
    logic [15:0] ch_data [N];
    bit          ch_last [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int seen_id_at(input int pos);
        return (pos < seen_id.size()) ? seen_id[pos] : -1;
    endfunction

    function automatic int seen_last_at(input int pos);
        return (pos < seen_last.size()) ? seen_last[pos] : -1;
    endfunction

    task automatic model_reset();
        owner = -1; rr = 0;
        exp_valid = 1'b0; exp_data = 16'h0000; exp_id = 0; exp_last = 1'b0;
        m_frames = 0; m_gap = 1'b0;
    endtask

    // Which child the rules say may move a beat now (-1 for none).
    function automatic int model_grant();
        if (owner >= 0) return in_valid[owner] ? owner : -1;
        for (int k = 0; k < N; k++) begin
            if (in_valid[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_idle();
        in_valid = '0; in_last = '0; in_data = '0;
    endtask

    task automatic put(input int c, input logic [15:0] d, input bit l);
        in_valid[c] = 1'b1;
        in_data[c*DW +: DW] = d;
        in_last[c] = l;
    endtask

    // One cycle: compare after inputs settle, then advance the model at the edge.
    // Called at a falling edge with the inputs already driven.
    task automatic step();
        int g;
        bit load;
        bit gap;
        logic [N-1:0] er;
        #1;
        if (!rst_n) model_reset();
        load = !exp_valid || out_ready;
        g    = model_grant();
        er   = '0;
        if (rst_n && load && g >= 0) er[g] = 1'b1;
        gap  = rst_n && owner >= 0 && load && !in_valid[owner];
        chk("in_ready",  64'(in_ready),  64'(er));
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        chk("out_data",  64'(out_data),  64'(exp_data));
        chk("out_id",    64'(out_id),    64'(exp_id));
        chk("out_last",  64'(out_last),  64'(exp_last));
`ifdef COLLECTOR_STATS_EN
        chk("frame_cnt", 64'(frame_cnt), 64'(m_frames));
        chk("err_gap",   64'(err_gap),   64'(m_gap));
`endif
        obs_valid = out_valid;
        obs_data  = out_data;
        obs_ready = in_ready;
        if (out_valid && out_ready) begin
            seen_id.push_back(int'(out_id));
            seen_last.push_back(int'(out_last));
        end
        last_acc = -1;
        @(posedge clk);
        if (rst_n) begin
            if (gap) m_gap = 1'b1;
            if (load && g >= 0) begin
                last_acc  = g;
                exp_valid = 1'b1;
                exp_data  = in_data[g*DW +: DW];
                exp_id    = g;
                exp_last  = in_last[g];
                if (in_last[g]) begin
                    owner = -1;
                    rr    = (g + 1) % N;
                    if (m_frames < 65535) m_frames++;
                end else begin
                    owner = g;
                end
            end else if (out_ready) begin
                exp_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        set_idle();
        model_reset();
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;

        // Idle after reset: nothing valid, nothing ready.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_valid", 64'(obs_valid), 64'd0);
            chk("idle_ready", 64'(obs_ready), 64'd0);
        end

        // Fairness: every child offers single-beat frames.
        seen_id.delete(); seen_last.delete();
        for (int i = 0; i < 6; i++) begin
            set_idle();
            for (int c = 0; c < N; c++) put(c, 16'(16'h0100 + c), 1'b1);
            step();
        end
        set_idle();
        step();
        chk("fair_n", 64'(seen_id.size()), 64'd6);
        chk("fair_0", 64'(seen_id_at(0)), 64'd0);
        chk("fair_1", 64'(seen_id_at(1)), 64'd1);
        chk("fair_2", 64'(seen_id_at(2)), 64'd2);
        chk("fair_3", 64'(seen_id_at(3)), 64'd3);
        chk("fair_4", 64'(seen_id_at(4)), 64'd4);
        chk("fair_5", 64'(seen_id_at(5)), 64'd0);

        // No interleave: child 2 sends A,B,C while child 0 waits throughout.
        seen_id.delete(); seen_last.delete();
        set_idle(); put(0, 16'h00A0, 1'b1); put(2, 16'h000A, 1'b0); step();
        set_idle(); put(0, 16'h00A0, 1'b1); put(2, 16'h000B, 1'b0); step();
        set_idle(); put(0, 16'h00A0, 1'b1); put(2, 16'h000C, 1'b1); step();
        set_idle(); put(0, 16'h00A0, 1'b1); step();
        set_idle(); step();
        set_idle(); step();
        chk("nil_id0", 64'(seen_id_at(0)), 64'd2);
        chk("nil_id1", 64'(seen_id_at(1)), 64'd2);
        chk("nil_id2", 64'(seen_id_at(2)), 64'd2);
        chk("nil_id3", 64'(seen_id_at(3)), 64'd0);
        chk("nil_l0",  64'(seen_last_at(0)), 64'd0);
        chk("nil_l1",  64'(seen_last_at(1)), 64'd0);
        chk("nil_l2",  64'(seen_last_at(2)), 64'd1);

        // Backpressure: 0x1234 held for four stalled cycles.
        out_ready = 1'b1;
        set_idle(); put(1, 16'h1234, 1'b1); step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_idle(); put(3, 16'h5678, 1'b1); step();
            chk("bp_data",  64'(obs_data),  64'h1234);
            chk("bp_ready", 64'(obs_ready), 64'd0);
        end
        out_ready = 1'b1;
        set_idle(); put(3, 16'h5678, 1'b1); step();
        chk("bp_drain_ready", 64'(obs_ready), 64'b01000);
        set_idle(); step();
        chk("bp_next", 64'(obs_data), 64'h5678);

        // Wrap: pointer at 4, children 4 and 1 competing.
        seen_id.delete(); seen_last.delete();
        for (int i = 0; i < 3; i++) begin
            set_idle(); put(4, 16'h0444, 1'b1); put(1, 16'h0111, 1'b1); step();
        end
        set_idle(); step();
        chk("wrap_0", 64'(seen_id_at(0)), 64'd4);
        chk("wrap_1", 64'(seen_id_at(1)), 64'd1);
        chk("wrap_2", 64'(seen_id_at(2)), 64'd4);

        // Reset in the middle of a 4-beat frame from child 3.
        set_idle(); put(3, 16'h3001, 1'b0); step();
        set_idle(); put(3, 16'h3002, 1'b0); step();
        set_idle(); put(3, 16'h3003, 1'b0);
        rst_n = 1'b0;
        step();
        chk("rst_valid", 64'(obs_valid), 64'd0);
        chk("rst_ready", 64'(obs_ready), 64'd0);
`ifdef COLLECTOR_STATS_EN
        chk("rst_frames", 64'(frame_cnt), 64'd0);
`endif
        step();
        rst_n = 1'b1;
        seen_id.delete(); seen_last.delete();
        set_idle();
        for (int c = 0; c < N; c++) put(c, 16'(16'h0200 + c), 1'b1);
        step();
        set_idle(); step();
        chk("rst_first", 64'(seen_id_at(0)), 64'd0);

        // Random traffic: frames of 1..4 beats, gaps, and random backpressure.
        for (int c = 0; c < N; c++) begin
            ch_has[c] = 1'b0; ch_left[c] = 0; ch_data[c] = 16'h0000; ch_last[c] = 1'b0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (!ch_has[c] && ($urandom_range(2, 0) == 0)) begin
                    if (ch_left[c] == 0) ch_left[c] = $urandom_range(4, 1);
                    ch_data[c] = 16'($urandom);
                    ch_last[c] = (ch_left[c] == 1);
                    ch_has[c]  = 1'b1;
                end
            end
            set_idle();
            for (int c = 0; c < N; c++) begin
                if (ch_has[c]) put(c, ch_data[c], ch_last[c]);
            end
            out_ready = ($urandom_range(3, 0) != 0);
            step();
            if (last_acc >= 0) begin
                ch_has[last_acc]  = 1'b0;
                ch_left[last_acc] = ch_left[last_acc] - 1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
